// File: rtl/mem_read_streamer.sv
// mem_read_streamer
//
// Reads a block of consecutive words from the registered-output memory array
// and streams them out on a valid/ready interface. A 2-entry output buffer
// absorbs backpressure; reads are only issued when the buffer plus the read in
// flight has room for the returning word.
//
// Ports:
//   clk, rst        clock and synchronous active-high reset
//   start           begin a block read (sampled only in IDLE)
//   base_addr       first address of the block (sampled with start)
//   length          word count, 0 .. 2**ADDR_W (sampled with start)
//   busy            block read in progress, including the DONE cycle
//   mem_addr/mem_re read request to the memory array
//   mem_rdata       memory read data, valid the cycle after mem_re
//   out_data/out_valid/out_ready  output stream
//   done            one-cycle pulse after the last word is accepted
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for start
// READ  | issuing reads while words remain and the buffer has room
// DRAIN | all reads issued; waiting for the buffer to empty
// DONE  | last word accepted; done and busy high for one cycle

module mem_read_streamer #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   length,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     remaining_q;
    logic                inflight_q;
    logic [DATA_W-1:0]   buf0_q, buf1_q;
    logic [1:0]          count_q;
    logic                zero_done_q;
    logic                push, pop, room, accept;

    // The word requested last cycle is on mem_rdata now; push it.
    assign push   = inflight_q;
    assign pop    = out_valid && out_ready;
    assign room   = (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd2) || pop;
    assign accept = (state_q == S_IDLE) && start && (length != '0);

    assign mem_re    = (state_q == S_READ) && (remaining_q != '0) && room;
    assign mem_addr  = addr_q;
    assign out_data  = buf0_q;
    assign out_valid = (count_q != 2'd0);
    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) || zero_done_q;

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_READ;
            S_READ:  if (remaining_q == '0) state_d = S_DRAIN;
            // Leave on the cycle of the final pop so done follows it directly.
            S_DRAIN: if (!inflight_q && ((count_q == 2'd0) || (count_q == 2'd1 && pop)))
                         state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q      <= '0;
            remaining_q <= '0;
            inflight_q  <= 1'b0;
            buf0_q      <= '0;
            buf1_q      <= '0;
            count_q     <= 2'd0;
            zero_done_q <= 1'b0;
        end else begin
            assert (!(push && !pop && count_q == 2'd2));

            zero_done_q <= (state_q == S_IDLE) && start && (length == '0);
            inflight_q  <= mem_re;

            if (accept) begin
                addr_q      <= base_addr;
                remaining_q <= length;
            end else if (mem_re) begin
                addr_q      <= addr_q + 1'b1;
                remaining_q <= remaining_q - 1'b1;
            end

            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) buf0_q <= mem_rdata;
                    else                 buf1_q <= mem_rdata;
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    buf0_q  <= buf1_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        buf0_q <= mem_rdata;
                    end else begin
                        buf0_q <= buf1_q;
                        buf1_q <= mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_read_streamer.sv
module tb_mem_read_streamer;

    localparam int DW = 8;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   length;
    logic          busy;
    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic          done;

    mem_read_streamer #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .mem_addr  (mem_addr),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .done      (done)
    );

    always #5 clk = ~clk;

    // memory array: mem[i] = i + 0x10, registered read
    logic [DW-1:0] mem [16];
    always @(posedge clk) if (mem_re) mem_rdata <= mem[mem_addr];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // monitor state
    int cyc = 0;
    int got_q[$];
    int addr_q[$];
    int issued, xfer, done_cnt, first_valid, done_cyc, last_xfer, start_cyc;
    int stall_viol, occ_viol, stall_seen;
    logic          stall_prev;
    logic [DW-1:0] stall_data;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        int occ;
        if (start && !busy) start_cyc = cyc;
        if (out_valid && first_valid < 0) first_valid = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (stall_prev && (!out_valid || out_data !== stall_data)) stall_viol++;
        stall_prev = out_valid && !out_ready;
        stall_data = out_data;
        if (stall_prev) stall_seen++;
        occ = issued - xfer;
        if (occ > 2) occ_viol++;
        if (mem_re && occ >= 2 && !(out_valid && out_ready)) occ_viol++;
        if (mem_re) begin
            addr_q.push_back(int'(mem_addr));
            issued++;
        end
        if (out_valid && out_ready) begin
            got_q.push_back(int'(out_data));
            xfer++;
            last_xfer = cyc;
        end
    end

    task automatic clear_mon();
        got_q.delete();
        addr_q.delete();
        issued = 0; xfer = 0; done_cnt = 0;
        first_valid = -1; done_cyc = -1; last_xfer = -1; start_cyc = -1;
        stall_viol = 0; occ_viol = 0; stall_seen = 0;
        stall_prev = 1'b0;
    endtask

    function automatic int got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : -1;
    endfunction

    function automatic int addr_at(input int i);
        return (i < addr_q.size()) ? addr_q[i] : -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_block(input int b, input int l);
        start     = 1'b1;
        base_addr = b[AW-1:0];
        length    = l[AW:0];
        tick();
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy && k < 300) begin
            tick();
            k++;
        end
        if (busy) check_val("idle_timeout", 1, 0);
        tick();
    endtask

    task automatic check_outputs_zero(input string pfx);
        check_val({pfx, "_busy"},      int'(busy),      0);
        check_val({pfx, "_mem_re"},    int'(mem_re),    0);
        check_val({pfx, "_out_valid"}, int'(out_valid), 0);
        check_val({pfx, "_done"},      int'(done),      0);
        check_val({pfx, "_mem_addr"},  int'(mem_addr),  0);
        check_val({pfx, "_out_data"},  int'(out_data),  0);
    endtask

    initial begin
        int pat[6];
        int wrap_a[4];
        pat    = '{1, 0, 0, 1, 0, 1};
        wrap_a = '{14, 15, 0, 1};
        for (int i = 0; i < 16; i++) mem[i] = 8'(i + 'h10);

        rst = 1'b1; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b1;
        clear_mon();
        tick();
        tick();
        check_outputs_zero("reset");
        rst = 1'b0;
        tick();

        // reset in the middle of a block, during the 4th transfer
        clear_mon();
        start_block(0, 8);
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("rstmid_xfers_before", got_q.size(), 4);
        check_val("rstmid_4th_word", got_at(3), 'h13);
        check_outputs_zero("rstmid");
        clear_mon();
        repeat (6) tick();
        check_val("rstmid_no_valid_after", got_q.size(), 0);
        check_val("rstmid_no_done", done_cnt, 0);
        start_block(2, 1);
        wait_idle();
        check_val("rstmid_new_count", got_q.size(), 1);
        check_val("rstmid_new_word", got_at(0), 'h12);
        check_val("rstmid_new_done", done_cnt, 1);

        // basic read
        clear_mon();
        start_block(3, 4);
        wait_idle();
        check_val("basic_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++) check_val($sformatf("basic_word%0d", i), got_at(i), 'h13 + i);
        // start is high in cycle c; E0 ends it, so the second cycle after E0 is c+3
        check_val("basic_first_valid", first_valid - start_cyc, 3);
        check_val("basic_done_lat", done_cyc - start_cyc, 7);
        check_val("basic_done_after_last", done_cyc - last_xfer, 1);
        check_val("basic_done_cnt", done_cnt, 1);
        check_val("basic_busy_after", int'(busy), 0);

        // wrap-around
        clear_mon();
        start_block(14, 4);
        wait_idle();
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("wrap_addr%0d", i), addr_at(i), wrap_a[i]);
            check_val($sformatf("wrap_word%0d", i), got_at(i), 'h10 + wrap_a[i]);
        end

        // backpressure
        clear_mon();
        start_block(0, 6);
        for (int i = 0; i < 6; i++) begin
            out_ready = pat[i][0];
            tick();
        end
        out_ready = 1'b1;
        wait_idle();
        check_val("bp_count", got_q.size(), 6);
        for (int i = 0; i < 6; i++) check_val($sformatf("bp_word%0d", i), got_at(i), 'h10 + i);
        check_val("bp_stall_seen", int'(stall_seen > 0), 1);
        check_val("bp_stall_stable", stall_viol, 0);
        check_val("bp_outstanding", occ_viol, 0);
        check_val("bp_reads", issued, 6);
        check_val("bp_done_cnt", done_cnt, 1);

        // length 0
        clear_mon();
        start = 1'b1; base_addr = 4'd0; length = 5'd0;
        tick();
        start = 1'b0;
        check_val("len0_done", int'(done), 1);
        check_val("len0_busy", int'(busy), 0);
        tick();
        check_val("len0_done_end", int'(done), 0);
        check_val("len0_busy_end", int'(busy), 0);
        check_val("len0_done_cnt", done_cnt, 1);
        check_val("len0_reads", issued, 0);

        // full length, wrapping from base 5
        clear_mon();
        start_block(5, 16);
        wait_idle();
        check_val("len16_count", got_q.size(), 16);
        check_val("len16_reads", issued, 16);
        for (int i = 0; i < 16; i++) begin
            check_val($sformatf("len16_addr%0d", i), addr_at(i), (5 + i) % 16);
            check_val($sformatf("len16_word%0d", i), got_at(i), 'h10 + ((5 + i) % 16));
        end

        // start while busy is ignored
        clear_mon();
        start_block(8, 4);
        tick();
        start = 1'b1; base_addr = 4'd0; length = 5'd2;
        tick();
        start = 1'b0;
        wait_idle();
        repeat (4) tick();
        check_val("ign_count", got_q.size(), 4);
        check_val("ign_reads", issued, 4);
        check_val("ign_done_cnt", done_cnt, 1);
        for (int i = 0; i < 4; i++) begin
            check_val($sformatf("ign_addr%0d", i), addr_at(i), 8 + i);
            check_val($sformatf("ign_word%0d", i), got_at(i), 'h18 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mem_read_streamer.md
Name: mem_read_streamer

Overview:
Reads a block of consecutive words from the flop-based memory array and streams them out over a valid/ready interface. This is the read-side counterpart of the memory write path. The memory registers its read data on posedge clk, so read data is returned exactly one cycle after a request. A 2-entry output buffer absorbs downstream backpressure, so no word is ever lost or duplicated.

Parameters:
DATA_W, 8, width of a memory word
ADDR_W, 4, memory address width; memory depth is 2**ADDR_W, and addresses wrap modulo that depth

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous active-high reset
start  input  1  single-cycle request to begin a block read; sampled only in IDLE
base_addr  input  ADDR_W  first address to read; sampled with start
length  input  ADDR_W+1  number of words to read, 0 to 2**ADDR_W; sampled with start
busy  output  1  high while a block read is in progress, including the DONE cycle
mem_addr  output  ADDR_W  read address to the memory array
mem_re  output  1  read request; memory presents mem_rdata on the following cycle
mem_rdata  input  DATA_W  registered read data from the memory array
out_data  output  DATA_W  head-of-buffer word
out_valid  output  1  out_data is valid
out_ready  input  1  downstream accepts the word; transfer occurs when out_valid && out_ready
done  output  1  one-cycle pulse when the last word has been transferred downstream

Behaviour:
- Single clock domain: clk.
- Reset (rst=1, synchronous):
  - state goes to IDLE; busy, mem_re, out_valid and done are 0; mem_addr and out_data are 0.
  - The buffer is flushed.
  - Any in-flight read is discarded; mem_rdata arriving in the cycle after reset is ignored.
- States:
  - IDLE: busy=0. If start=1 and length!=0: latch addr=base_addr and remaining=length, then go to READ. If start=1 and length==0: pulse done the next cycle and stay in IDLE with busy=0.
  - READ: issue reads until remaining==0, then go to DRAIN.
  - DRAIN: wait until no read is in flight and the buffer is empty, then go to DONE.
  - DONE: done=1 and busy=1 for exactly one cycle, then go to IDLE.
- start is ignored in every state except IDLE.
- Read issue rule (combinational from registered state):
  - mem_re = (state==READ) && remaining!=0 && room.
  - room = (buf_count + inflight) < 2 || (out_valid && out_ready).
  - When a read issues: addr <= addr+1 (wraps from 2**ADDR_W-1 to 0), remaining <= remaining-1, inflight <= 1.
  - mem_addr = addr.
- Return path:
  - In the cycle after mem_re, mem_rdata is pushed into the buffer.
  - A push and a pop in the same cycle are both performed.
  - The buffer never overflows; the room rule guarantees this, and an overflow is an assertion failure.
- Ordering: words leave in address order, with no gaps, duplicates or reordering.
- Latency: start sampled at edge E0, mem_re high during cycle E0–E1, out_valid high after E2. The first word is therefore visible two cycles after start.
- Throughput: with out_ready held at 1, one word per cycle. A block of N words gives done at edge E0+N+2.
- Backpressure:
  - While out_valid && !out_ready, out_data and out_valid hold stable.
  - At most 2 words are buffered; reads stall once the buffer plus the in-flight read reach 2.
- Full length: length = 2**ADDR_W reads every location exactly once, starting at base_addr and wrapping.
- done is asserted only after the final transfer handshake, never before.

Test Plan:
- Reset mid-block: start base=0, length=8; assert rst for 1 cycle at the 4th transfer. Required: all outputs 0 the following cycle, no further out_valid, no done. A new start base=2, length=1 then returns mem[2] only.
- Basic read: mem[i]=i+0x10, start base=3, length=4, out_ready=1. Required: out_data 0x13, 0x14, 0x15, 0x16 on consecutive cycles; first out_valid 2 cycles after start; done 1 cycle after the last transfer; busy low afterwards.
- Wrap-around: base=14, length=4 (ADDR_W=4). Required: mem_addr sequence 14, 15, 0, 1 and out_data in that order.
- Backpressure: base=0, length=6, out_ready toggling 1,0,0,1,0,1 then held at 1. Required: exactly 6 transfers of mem[0..5] in order; out_data stable while stalled; at most 2 reads outstanding; no mem_re while the buffer is full with no pop.
- Edge lengths and ignored start:
  - length=0: done pulses once and busy stays 0.
  - length=16: all 16 words are read once.
  - A start pulse asserted while busy=1 has no effect on the addresses or the count.
